// File: rtl/fir_output_stage_pkg.sv
// Shared widths, defaults and sample typedefs for the FIR output stage.
// Also holds the counter-width helper used by the stage and its FIFO.
package fir_output_stage_pkg;

  localparam int FIR_IN_W       = 32;
  localparam int FIR_ORDER      = 4;
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_SHIFT      = 8;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef logic signed [FIR_IN_W-1:0]  in_sample_t;
  typedef logic signed [DEF_OUT_W-1:0] out_sample_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO: the head is visible on dout_o while not empty.
// Push into a full FIFO is accepted only together with a pop; clr_i empties it at the next edge.
module fir_out_fifo
  import fir_output_stage_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fir_output_stage.sv
// Drops FIR start-up samples, decimates, rounds/saturates to OUT_W and queues results for the consumer.
// Two edges from in_valid to FIFO head; a kept sample meeting a full, non-popping FIFO is dropped and counted.
module fir_output_stage
  import fir_output_stage_pkg::*;
#(
  parameter int IN_W       = FIR_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int DECIM      = DEF_DECIM,
  parameter int WARMUP     = FIR_ORDER - 1,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        sat_event,
  output logic                        overflow_flag,
  output logic [15:0]                 drop_count
);

  localparam int WW = cnt_w(WARMUP + 1);
  localparam int DW = cnt_w(DECIM);
  localparam logic signed [IN_W:0] RND     = ((IN_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [WW-1:0]      warm_cnt_q, warm_cnt_d;
  logic [DW-1:0]      dec_cnt_q, dec_cnt_d;
  logic               accept, warm_done, keep;
  logic signed [IN_W:0] sum_s, shr_s;
  logic [OUT_W-1:0]   scaled;
  logic               sat;
  logic               s1_vld_q, s1_sat_q;
  logic [OUT_W-1:0]   s1_dat_q;
  logic               fifo_full, fifo_empty, push, pop, drop;
  logic [OUT_W-1:0]   head;
  logic               overflow_q;
  logic [15:0]        drop_count_q;

  // A sample arriving together with flush is discarded and does not advance warm-up.
  assign accept    = in_valid && !flush;
  assign warm_done = (warm_cnt_q == WW'(WARMUP));
  assign keep      = accept && warm_done && (dec_cnt_q == '0);

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    if (flush) begin
      warm_cnt_d = '0;
      dec_cnt_d  = '0;
    end else if (accept) begin
      if (!warm_done)                   warm_cnt_d = warm_cnt_q + 1'b1;
      else if (dec_cnt_q == DW'(DECIM-1)) dec_cnt_d = '0;
      else                              dec_cnt_d  = dec_cnt_q + 1'b1;
    end
  end

  // One extra bit keeps the rounding add from wrapping at the top of the input range.
  always_comb begin
    sum_s  = $signed({in_y[IN_W-1], in_y}) + RND;
    shr_s  = sum_s >>> SHIFT;
    sat    = 1'b1;
    scaled = shr_s[OUT_W-1:0];
    if (shr_s > SAT_MAX)      scaled = SAT_MAX[OUT_W-1:0];
    else if (shr_s < SAT_MIN) scaled = SAT_MIN[OUT_W-1:0];
    else                      sat    = 1'b0;
  end

  assign pop  = out_valid && out_ready;
  assign push = s1_vld_q && !flush && (!fifo_full || pop);
  assign drop = s1_vld_q && !flush && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt_q   <= '0;
      dec_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_sat_q     <= 1'b0;
      s1_dat_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      s1_vld_q   <= keep;
      if (keep) begin
        s1_dat_q <= scaled;
        s1_sat_q <= sat;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (s1_dat_q),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

  assign out_valid     = !fifo_empty;
  assign out_data      = out_valid ? head : '0;
  assign sat_event     = push && s1_sat_q;
  assign overflow_flag = overflow_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed scenarios plus random traffic for fir_output_stage, checked every cycle against
// a queue-based reference model of keep/scale/FIFO behaviour.
module tb_fir_output_stage;

  localparam int IN_W = 32, OUT_W = 8, SHIFT = 4, DECIM = 2, WARMUP = 3, DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_y = '0;
  logic        out_valid, sat_event, overflow_flag;
  logic [7:0]  out_data;
  logic [2:0]  fill_level;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  fir_output_stage #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fill_level(fill_level),
    .sat_event(sat_event), .overflow_flag(overflow_flag), .drop_count(drop_count)
  );

  int n_vec = 0, n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         pend_vld, pend_sat;
  logic [7:0] pend_val;
  int         idx;
  bit         m_ovf;
  int         m_drop;
  logic [7:0] got[$];
  int         n_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scale(input logic [31:0] y, output logic [7:0] val, output bit s);
    longint t;
    t = longint'($signed(y)) + (longint'(1) << (SHIFT - 1));
    t = t >>> SHIFT;
    if (t > 127)       begin val = 8'h7F; s = 1'b1; end
    else if (t < -128) begin val = 8'h80; s = 1'b1; end
    else               begin val = t[7:0]; s = 1'b0; end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_vld = 1'b0;
    pend_sat = 1'b0;
    pend_val = '0;
    idx = 0;
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] y, input bit r, input bit f);
    bit pop, room, ss;
    logic [7:0] sv;
    if (f) begin
      mq.delete();
      pend_vld = 1'b0;
      idx = 0;
    end else begin
      pop  = (mq.size() != 0) && r;
      room = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (pend_vld) begin
        if (room) mq.push_back(pend_val);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      pend_vld = 1'b0;
      if (v) begin
        if (idx >= WARMUP && (idx - WARMUP) % DECIM == 0) begin
          scale(y, sv, ss);
          pend_vld = 1'b1;
          pend_val = sv;
          pend_sat = ss;
        end
        idx++;
      end
    end
  endtask

  task automatic compare_all(input bit r, input bit f);
    int sz;
    bit ev;
    sz = mq.size();
    ev = (sz != 0);
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("fill_level", 32'(fill_level), 32'(sz));
    chk("sat_event", 32'(sat_event), 32'(pend_vld && pend_sat && !f && (sz < DEPTH || (r && sz > 0))));
    chk("overflow_flag", 32'(overflow_flag), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    if (out_valid && out_ready) got.push_back(out_data);
    if (sat_event) n_sat++;
  endtask

  // Drive one cycle's inputs, check just before the edge, then advance the model across it.
  task automatic cyc(input bit v, input logic [31:0] y, input bit r, input bit f);
    in_valid = v; in_y = y; out_ready = r; flush = f;
    @(negedge clk);
    compare_all(r, f);
    @(posedge clk);
    model_edge(v, y, r, f);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all(out_ready, 1'b0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string tag, input int n, input logic [39:0] e);
    chk(tag, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk(tag, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(e[8*i +: 8]));
  endtask

  initial begin
    logic [31:0] ry;
    // 1: warm-up and decimation
    do_reset();
    got.delete();
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'(16 * k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s1_outputs", 4, {8'h00, 8'd9, 8'd7, 8'd5, 8'd3});

    // 2: rounding
    do_reset();
    got.delete();
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd24, 1'b1, 1'b0);  cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, -32'sd24, 1'b1, 1'b0); cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd8, 1'b1, 1'b0);   cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd7, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s2_rounding", 4, {8'h00, 8'h00, 8'h01, 8'hFF, 8'h02});

    // 3: saturation
    do_reset();
    got.delete();
    n_sat = 0;
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd4096, 1'b1, 1'b0);  cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, -32'sd4096, 1'b1, 1'b0); cyc(1'b1, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd2032, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s3_saturation", 3, {8'h00, 8'h00, 8'h7F, 8'h80, 8'h7F});
    chk("s3_sat_pulses", 32'(n_sat), 32'd2);

    // 4: overflow, read-back order, push into full FIFO alongside a pop
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'd0, 1'b0, 1'b0);
    for (int j = 1; j <= 12; j++) cyc(1'b1, 32'(16 * j), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("s4_fill", 32'(fill_level), 32'd4);
    chk("s4_drops", 32'(drop_count), 32'd2);
    chk("s4_ovf", 32'(overflow_flag), 32'd1);
    cyc(1'b1, 32'(16 * 20), 1'b0, 1'b0);
    got.delete();
    for (int k = 0; k < 6; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s4_readback", 5, {8'd20, 8'd7, 8'd5, 8'd3, 8'd1});
    chk("s4_no_new_drop", 32'(drop_count), 32'd2);

    // 6: flush keeps sticky overflow and restarts warm-up
    for (int k = 16; k < 20; k++) cyc(1'b1, 32'(16 * k), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("s6_fill_before", 32'(fill_level), 32'd2);
    cyc(1'b1, 32'(16 * 50), 1'b0, 1'b1);
    chk("s6_fill_after", 32'(fill_level), 32'd0);
    chk("s6_ovf_kept", 32'(overflow_flag), 32'd1);
    got.delete();
    for (int k = 30; k < 34; k++) cyc(1'b1, 32'(16 * k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s6_after_flush", 1, {32'd0, 8'd33});

    // 5: asynchronous reset mid-operation
    for (int k = 40; k < 46; k++) cyc(1'b1, 32'(16 * k), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("s5_fill_before", 32'(fill_level), 32'd3);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("s5_valid_async", 32'(out_valid), 32'd0);
    chk("s5_fill_async", 32'(fill_level), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    got.delete();
    for (int k = 5; k < 9; k++) cyc(1'b1, 32'(16 * k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk_got("s5_rewarm", 1, {32'd0, 8'd8});

    // Random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 2))
        0:       ry = 32'($signed($urandom_range(0, 1023)) - 512);
        1:       ry = 32'($signed($urandom_range(0, 8191)) - 4096);
        default: ry = $urandom;
      endcase
      cyc($urandom_range(0, 3) != 0, ry, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
